// File: rtl/maple_data_encoder_if.sv
// Byte-stream and two-wire line bundle between the packet builder, the Maple
// encoder and the pad drivers.
interface maple_data_encoder_if;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic       sdcka_out;
    logic       sdckb_out;
    logic       drive_en;
    logic       busy;

    modport master (
        output in_data, in_last, in_valid,
        input  in_ready, sdcka_out, sdckb_out, drive_en, busy
    );

    modport slave (
        input  in_data, in_last, in_valid,
        output in_ready, sdcka_out, sdckb_out, drive_en, busy
    );
endinterface

// File: rtl/maple_data_encoder.sv
// Maple bus transmitter: frames bytes as start pattern, MSB-first phase-1/phase-2
// data bits and end pattern on SDCKA/SDCKB, each level held for TICKS clocks.
module maple_data_encoder #(
    parameter int TICKS = 4,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    maple_data_encoder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, WAIT, END} state_t;

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] tick, tick_n;
    logic [3:0]       step, step_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [1:0]       sub, sub_n;
    logic [7:0]       data_q, data_n;
    logic             last, last_n;
    logic             a, a_n, b, b_n;
    logic             drive, drive_n, busy_q, busy_n, ready, ready_n;
    logic             step_wrap, transfer;

    // Start: A low, then B toggles 0/1 four times, then A back high.
    function automatic logic [1:0] start_level(input logic [3:0] s);
        logic [1:0] lv;
        if (s == 4'd0)      lv = 2'b01;
        else if (s == 4'd9) lv = 2'b11;
        else                lv = {1'b0, ~s[0]};
        return lv;
    endfunction

    // Odd bit indices: B carries the bit, A is the clock; even: the reverse.
    function automatic logic [1:0] data_level(input logic [2:0] idx, input logic [1:0] ph,
                                              input logic val);
        logic [1:0] lv;
        if (idx[0]) begin
            case (ph)
                2'd0:    lv = {1'b1, val};
                2'd1:    lv = {1'b0, val};
                default: lv = 2'b01;
            endcase
        end else begin
            case (ph)
                2'd0:    lv = {val, 1'b1};
                2'd1:    lv = {val, 1'b0};
                default: lv = 2'b10;
            endcase
        end
        return lv;
    endfunction

    function automatic logic [1:0] end_level(input logic [3:0] s);
        logic [1:0] lv;
        if (s == 4'd4) lv = 2'b11;
        else           lv = {s[0], 1'b0};
        return lv;
    endfunction

    assign step_wrap = (tick == LAST_TICK);
    assign transfer  = bus.in_valid & ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            step    <= '0;
            bit_idx <= '0;
            sub     <= '0;
            data_q  <= '0;
            last    <= 1'b0;
            a       <= 1'b1;
            b       <= 1'b1;
            drive   <= 1'b0;
            busy_q  <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            step    <= step_n;
            bit_idx <= bit_idx_n;
            sub     <= sub_n;
            data_q  <= data_n;
            last    <= last_n;
            a       <= a_n;
            b       <= b_n;
            drive   <= drive_n;
            busy_q  <= busy_n;
            ready   <= ready_n;
        end
    end

    always_comb begin
        state_n   = state;
        tick_n    = tick;
        step_n    = step;
        bit_idx_n = bit_idx;
        sub_n     = sub;
        data_n    = data_q;
        last_n    = last;
        a_n       = a;
        b_n       = b;
        drive_n   = drive;
        busy_n    = busy_q;
        ready_n   = ready;
        if (state == START || state == DATA || state == END)
            tick_n = step_wrap ? '0 : tick + CNT_W'(1);
        case (state)
            IDLE: if (transfer) begin
                data_n     = bus.in_data;
                last_n     = bus.in_last;
                state_n    = START;
                step_n     = '0;
                tick_n     = '0;
                {a_n, b_n} = start_level(4'd0);
                drive_n    = 1'b1;
                busy_n     = 1'b1;
                ready_n    = 1'b0;
            end
            START: if (step_wrap) begin
                if (step == 4'd9) begin
                    state_n    = DATA;
                    bit_idx_n  = 3'd7;
                    sub_n      = 2'd0;
                    {a_n, b_n} = data_level(3'd7, 2'd0, data_q[7]);
                end else begin
                    step_n     = step + 4'd1;
                    {a_n, b_n} = start_level(step + 4'd1);
                end
            end
            DATA: if (step_wrap) begin
                if (sub != 2'd2) begin
                    sub_n      = sub + 2'd1;
                    {a_n, b_n} = data_level(bit_idx, sub + 2'd1, data_q[bit_idx]);
                end else if (bit_idx != 3'd0) begin
                    bit_idx_n  = bit_idx - 3'd1;
                    sub_n      = 2'd0;
                    {a_n, b_n} = data_level(bit_idx - 3'd1, 2'd0, data_q[bit_idx - 3'd1]);
                end else if (last) begin
                    state_n    = END;
                    step_n     = '0;
                    {a_n, b_n} = end_level(4'd0);
                end else begin
                    // Lines already rest at A=1,B=0 after a phase-2 bit.
                    state_n = WAIT;
                    ready_n = 1'b1;
                end
            end
            WAIT: if (transfer) begin
                data_n     = bus.in_data;
                last_n     = bus.in_last;
                state_n    = DATA;
                bit_idx_n  = 3'd7;
                sub_n      = 2'd0;
                tick_n     = '0;
                {a_n, b_n} = data_level(3'd7, 2'd0, bus.in_data[7]);
                ready_n    = 1'b0;
            end
            END: if (step_wrap) begin
                if (step == 4'd4) begin
                    state_n = IDLE;
                    a_n     = 1'b1;
                    b_n     = 1'b1;
                    drive_n = 1'b0;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                end else begin
                    step_n     = step + 4'd1;
                    {a_n, b_n} = end_level(step + 4'd1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.in_ready  = ready;
    assign bus.sdcka_out = a;
    assign bus.sdckb_out = b;
    assign bus.drive_en  = drive;
    assign bus.busy      = busy_q;
endmodule

// File: doc/maple_data_encoder.md
Name: maple_data_encoder

Overview:
- Maple bus transmitter: serialises bytes onto the two-wire SDCKA/SDCKB bus as a framed packet (start pattern, data bits, end pattern).
- Output is decodable by the team's Maple data decoder: a phase-1 bit is sampled from SDCKB on an SDCKA fall; a phase-2 bit is sampled from SDCKA on an SDCKB fall; MSB first.
- Sits between the packet/CRC builder (byte stream with valid/ready) and the bidirectional pad drivers.

Parameters:
- TICKS, 4, clk cycles per bus step (≥1); sets bit rate.
- CNT_W, 16, width of the step-duration counter (must hold TICKS-1).

Ports:
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- in_data  input  8  byte to send
- in_last  input  1  qualifies in_data as final byte of frame
- in_valid  input  1  in_data/in_last valid
- in_ready  output  1  encoder accepts byte this cycle (transfer = in_valid & in_ready at posedge)
- sdcka_out  output  1  SDCKA drive value
- sdckb_out  output  1  SDCKB drive value
- drive_en  output  1  pad output enable, high from first start step to end of end pattern
- busy  output  1  high in any state except IDLE

Behaviour:
- All outputs registered. Reset/idle values: sdcka_out=1, sdckb_out=1, drive_en=0, busy=0, in_ready=1 (IDLE). Step counter=0, state=IDLE.
- Step = one output level held exactly TICKS clk cycles; counter runs 0..TICKS-1, next step on wrap.
- States: IDLE, START, DATA, WAIT, END.
- IDLE: on transfer, latch byte and last flag. Next cycle enter START with drive_en=1, busy=1, in_ready=0.
- START (10 steps from A=1,B=1):
  - A←0.
  - B←0,1,0,1,0,1,0,1 (4 B falls while A low).
  - A←1.
  - Go to DATA, bit index 7.
- DATA, bit order MSB first:
  - Bits 7,5,3,1 use phase-1 steps: B←bit; A←0; B←1.
  - Bits 6,4,2,0 use phase-2 steps: A←bit; B←0; A←1.
  - 3 steps per bit, so 24·TICKS cycles per byte.
  - No other falling edge is produced on the line acting as clock in that phase.
  - After bit 0: if latched last=1 go to END, else go to WAIT.
- WAIT: lines held at A=1, B=0; in_ready=1. On transfer, latch byte and go to DATA the next cycle. Underrun (no valid) stalls indefinitely with lines held.
- END (5 steps from A=1,B=0): A←0,1,0,1 (2 A falls while B low); then B←1. Then IDLE: drive_en=0, busy=0, in_ready=1.
- in_ready is high only in IDLE and WAIT; bytes are never accepted mid-byte. in_data is ignored when in_ready=0.
- reset mid-frame: next cycle all outputs return to reset values. No end pattern is emitted; the frame is abandoned.
- in_valid asserted in the same cycle as reset: ignored.

Test Plan:
- TICKS=1, single byte 0xA5 with last=1 → in_ready low next cycle. Start pattern: A low 9 cycles with 4 B falls. Then 24 data cycles, 5 end cycles. drive_en high 10+24+5=39 cycles; then idle at A=B=1.
- Loopback into the Maple data decoder (decoder reset at start of frame), TICKS=4, bytes 0x00,0xFF,0x3C (last on 0x3C) → decoder reports ready 3 times with data 0x00, 0xFF, 0x3C in order.
- Edge audit, random 16-byte frames: count SDCKA falls while SDCKB held and vice versa → exactly 4 A falls per byte and 4 B falls per byte, plus the start/end pattern falls. No other glitches.
- Underrun: withhold in_valid for 50 cycles after byte 1 → lines frozen at A=1,B=0, in_ready=1. Resume with 0x81 → correct decode, no extra edges.
- Reset asserted during bit 3 of a byte → next cycle sdcka_out=1, sdckb_out=1, drive_en=0, busy=0, in_ready=1. A new frame sent afterwards decodes correctly.
- TICKS=7 timing: every step measured at exactly 7 cycles; byte period is 168 cycles.
